// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle control FSM for a 9-bit, single-issue datapath.
// It fetches one instruction over a valid/ready handshake, steps it through
// decode / register read / execute / memory / writeback, and drives the
// register-file, ALU and data-memory controls plus PC increment/branch pulses.
// Memory accesses have variable latency and are bounded by a timeout that
// parks the sequencer in a sticky error state.
module regfile_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,  // MEM cycles without memAck before ERR (>=1)
  parameter int unsigned CNT_W       = 16   // width of the active-cycle counter
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic             instrValid,
  input  logic [8:0]       instruction,
  output logic             instrReady,
  input  logic             zeroFlag,
  input  logic             memAck,
  output logic [2:0]       readRegister1,
  output logic [2:0]       readRegister2,
  output logic             immediate,
  output logic             regWrite,
  output logic [1:0]       aluOp,
  output logic             wbSel,
  output logic             memReq,
  output logic             memWrite,
  output logic             pcInc,
  output logic             pcBranch,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] cycleCount
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_MOVI  = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    OP_BRZ   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  // The timer only ever holds 0 .. MEM_TIMEOUT-1; keep at least one bit so a
  // timeout of 1 still elaborates.
  localparam int unsigned TIMER_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [8:0]         ir_q, ir_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Instruction register fields.
  opcode_e    op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       is_alu;

  assign op     = opcode_e'(ir_q[8:6]);
  assign rd     = ir_q[5:3];
  assign rs     = ir_q[2:0];
  assign is_alu = (ir_q[8] == 1'b0);  // ADD, SUB, AND, MOVI share op[2]=0

  // State, instruction, timer and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, IR/timer update and all control outputs from state and IR.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    timer_d       = timer_q;
    instrReady    = 1'b0;
    readRegister1 = 3'd0;
    readRegister2 = 3'd0;
    immediate     = 1'b0;
    regWrite      = 1'b0;
    aluOp         = 2'b00;
    wbSel         = 1'b0;
    memReq        = 1'b0;
    memWrite      = 1'b0;
    pcInc         = 1'b0;
    pcBranch      = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        instrReady = 1'b1;
        if (instrValid) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        readRegister1 = rd;
        readRegister2 = rs;
        immediate     = (op == OP_MOVI);
        state_d       = (op == OP_HALT) ? S_HALT : S_READ;
      end

      // The register file read is registered: addresses are held one more
      // cycle so the operands are stable when EXEC uses them.
      S_READ: begin
        readRegister1 = rd;
        readRegister2 = rs;
        immediate     = (op == OP_MOVI);
        state_d       = S_EXEC;
      end

      S_EXEC: begin
        readRegister1 = rd;
        readRegister2 = rs;
        immediate     = (op == OP_MOVI);
        if (is_alu) begin
          aluOp   = ir_q[7:6];
          state_d = S_WB;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          timer_d = '0;
          state_d = S_MEM;
        end else if (op == OP_BRZ) begin
          pcBranch = zeroFlag;
          pcInc    = ~zeroFlag;
          state_d  = S_FETCH;
        end
      end

      // memAck takes priority over the timeout when both land together.
      S_MEM: begin
        memReq        = 1'b1;
        memWrite      = (op == OP_STORE);
        readRegister1 = rd;
        readRegister2 = rs;
        if (memAck) begin
          if (op == OP_STORE) begin
            pcInc   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          if (timer_q == TIMER_LAST) begin
            state_d = S_ERR;
          end
        end
      end

      S_WB: begin
        regWrite      = 1'b1;
        readRegister1 = rd;
        wbSel         = (op == OP_LOAD);
        pcInc         = 1'b1;
        state_d       = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      S_ERR: begin
        error = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Active-cycle counter: runs in the working states and saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q inside {S_FETCH, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB}) &&
        (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cycleCount = cnt_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer. For each instruction the bench
// derives a per-cycle timeline (which cycle after acceptance carries each
// control pulse or window) from the opcode, zeroFlag and the memAck delay, and
// compares every cycle's outputs and the active-cycle count against it.
module tb_regfile_sequencer;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;

  logic             clock = 1'b0;
  logic             resetN = 1'b1;
  logic             start = 1'b0;
  logic             instrValid = 1'b0;
  logic [8:0]       instruction = '0;
  logic             zeroFlag = 1'b0;
  logic             memAck = 1'b0;
  logic             instrReady;
  logic [2:0]       readRegister1;
  logic [2:0]       readRegister2;
  logic             immediate;
  logic             regWrite;
  logic [1:0]       aluOp;
  logic             wbSel;
  logic             memReq;
  logic             memWrite;
  logic             pcInc;
  logic             pcBranch;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] cycleCount;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  regfile_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .start         (start),
    .instrValid    (instrValid),
    .instruction   (instruction),
    .instrReady    (instrReady),
    .zeroFlag      (zeroFlag),
    .memAck        (memAck),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .immediate     (immediate),
    .regWrite      (regWrite),
    .aluOp         (aluOp),
    .wbSel         (wbSel),
    .memReq        (memReq),
    .memWrite      (memWrite),
    .pcInc         (pcInc),
    .pcBranch      (pcBranch),
    .halted        (halted),
    .error         (error),
    .cycleCount    (cycleCount)
  );

  always #5 clock = ~clock;

  // Observed control vector, in the same field order as pack_ctl().
  logic [17:0] obs_v;
  assign obs_v = {instrReady, readRegister1, readRegister2, immediate, regWrite,
                  aluOp, wbSel, memReq, memWrite, pcInc, pcBranch, halted, error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack_ctl(
      input logic rdy, input logic [2:0] r1, input logic [2:0] r2, input logic imm,
      input logic rw, input logic [1:0] alu, input logic wb, input logic mr,
      input logic mw, input logic pi, input logic pb, input logic h, input logic e);
    return {rdy, r1, r2, imm, rw, alu, wb, mr, mw, pi, pb, h, e};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check mid-cycle,
  // then account for the cycle in the expected active-cycle count.
  task automatic step(input logic v, input logic [8:0] ins, input logic zf,
                      input logic ack, input logic st, input logic [17:0] exp,
                      input logic active, input string tag);
    @(negedge clock);
    instrValid  = v;
    instruction = ins;
    zeroFlag    = zf;
    memAck      = ack;
    start       = st;
    #1;
    check(tag, 32'(obs_v), 32'(exp));
    check({tag, "/cnt"}, 32'(cycleCount), 32'(exp_cnt));
    if (active && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clock);
    #2;
    instrValid = 1'b0;
    memAck     = 1'b0;
    start      = 1'b0;
    resetN     = 1'b0;
    #1;
    check("reset/ctl", 32'(obs_v), 32'd0);
    check("reset/cnt", 32'(cycleCount), 32'd0);
    @(negedge clock);
    resetN  = 1'b1;
    exp_cnt = 0;
  endtask

  // Idle cycles (start low) then one start cycle; nothing counts while idle.
  task automatic do_start(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++)
      step(1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, "idle");
    step(1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'b1, '0, 1'b0, "start");
  endtask

  // Run one instruction from FETCH. ack_n = MEM cycle (1-based) carrying memAck,
  // 0 = never. gaps = FETCH cycles with instrValid low before acceptance.
  // stop_k >= 0 abandons the instruction before cycle stop_k.
  task automatic run_instr(input logic [8:0] ins, input logic zf, input int ack_n,
                           input int gaps, input int stop_k);
    logic [2:0]  op, rd, rs;
    logic        is_mem, timeout, v, z, a;
    logic [8:0]  ik;
    int          mem_end, wb_k, len;
    logic        rdy, imm, rw, wb, mr, mw, pi, pb, h, e;
    logic [2:0]  r1, r2;
    logic [1:0]  alu;
    string       tag;

    op      = ins[8:6];
    rd      = ins[5:3];
    rs      = ins[2:0];
    is_mem  = (op == 3'd4) || (op == 3'd5);
    timeout = is_mem && (ack_n == 0);
    mem_end = (ack_n > 0) ? 3 + ack_n : 3 + TIMEOUT;
    wb_k    = (op < 3'd4) ? 4 : ((op == 3'd4 && ack_n > 0) ? 4 + ack_n : -1);
    if (op < 3'd4)        len = 5;
    else if (op == 3'd6)  len = 4;
    else if (op == 3'd7)  len = 7;
    else if (timeout)     len = mem_end + 4;
    else if (op == 3'd4)  len = 5 + ack_n;
    else                  len = 4 + ack_n;

    for (int g = 0; g < gaps; g++)
      step(1'b0, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           pack_ctl(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
           1'b1, "fetch_wait");

    for (int k = 0; k < len; k++) begin
      if (k == stop_k) return;
      // Inputs: only the sampled ones are constrained, the rest are junk.
      v  = (k == 0) ? 1'b1 : 1'($urandom);
      ik = (k == 0) ? ins : 9'($urandom);
      z  = (k == 3) ? zf : 1'($urandom);
      if (is_mem && k >= 4 && k <= mem_end) a = (ack_n > 0) && (k == mem_end);
      else                                   a = 1'($urandom);

      {rdy, imm, rw, wb, mr, mw, pi, pb, h, e} = '0;
      r1  = 3'd0;
      r2  = 3'd0;
      alu = 2'd0;
      if (op == 3'd7 && k >= 2) begin
        h = 1'b1;
      end else if (timeout && k > mem_end) begin
        e = 1'b1;
      end else begin
        rdy = (k == 0);
        if (k >= 1 && k <= 3) begin
          r1  = rd;
          r2  = rs;
          imm = (op == 3'd3);
        end
        if (k == 3 && op < 3'd4) alu = op[1:0];
        if (k == 3 && op == 3'd6) begin
          pb = zf;
          pi = ~zf;
        end
        if (is_mem && k >= 4 && k <= mem_end) begin
          mr = 1'b1;
          mw = (op == 3'd5);
          r1 = rd;
          r2 = rs;
          if (op == 3'd5 && ack_n > 0 && k == mem_end) pi = 1'b1;
        end
        if (k == wb_k) begin
          rw = 1'b1;
          r1 = rd;
          wb = (op == 3'd4);
          pi = 1'b1;
        end
      end
      tag = $sformatf("op%0d/k%0d", op, k);
      step(v, ik, z, a, 1'($urandom),
           pack_ctl(rdy, r1, r2, imm, rw, alu, wb, mr, mw, pi, pb, h, e),
           !(h || e), tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;

    do_reset();
    do_start(2);

    // ADD r2,r3 with instrValid presented immediately.
    run_instr(9'b000_010_011, 1'b0, 0, 0, -1);
    // BRZ taken and not taken.
    run_instr(9'b110_001_101, 1'b1, 0, 1, -1);
    run_instr(9'b110_110_010, 1'b0, 0, 0, -1);
    // LOAD acknowledged on the third MEM cycle.
    run_instr(9'b100_101_001, 1'b0, 3, 0, -1);
    // STORE acknowledged on the very cycle the timeout would fire.
    run_instr(9'b101_011_100, 1'b0, TIMEOUT, 0, -1);
    // MOVI and SUB/AND directed.
    run_instr(9'b011_111_110, 1'b0, 0, 0, -1);
    run_instr(9'b001_100_010, 1'b0, 0, 2, -1);
    run_instr(9'b010_001_111, 1'b0, 0, 0, -1);

    // Random instruction stream (no HALT, no timeouts).
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 6));
      run_instr({op, 6'($urandom)}, 1'($urandom), $urandom_range(1, TIMEOUT),
                $urandom_range(0, 2), -1);
    end

    // STORE never acknowledged: error after TIMEOUT MEM cycles, sticky.
    run_instr(9'b101_010_001, 1'b0, 0, 0, -1);
    do_reset();
    do_start(1);

    // HALT: sticky, counter frozen, start and instrValid ignored.
    run_instr(9'b111_000_000, 1'b0, 0, 1, -1);
    do_reset();
    do_start(0);

    // LOAD abandoned mid-MEM by an asynchronous reset, then resume.
    run_instr(9'b100_011_010, 1'b0, 0, 0, 7);
    do_reset();
    do_start(1);
    run_instr(9'b000_001_010, 1'b0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
